// File: rtl/iob_axistream_out_pkg.sv
// Shared FSM encoding and sub-word sizing for the axistream_out transmitter.
package iob_axistream_out_pkg;

  localparam int unsigned DEF_DATA_W  = 32;
  localparam int unsigned DEF_TDATA_W = 8;
  localparam int unsigned R           = DEF_DATA_W / DEF_TDATA_W;
  localparam int unsigned R_W         = (R > 1) ? $clog2(R) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_SEND  = 2'd2,
    ST_DONE  = 2'd3
  } tx_state_t;

  function automatic int unsigned sub_words(input int unsigned data_w, input int unsigned tdata_w);
    return data_w / tdata_w;
  endfunction

  // A one-beat word still needs a 1-bit index register.
  function automatic int unsigned sub_idx_w(input int unsigned r);
    return (r > 1) ? $clog2(r) : 1;
  endfunction

endpackage

// File: rtl/iob_axistream_out_fifo.sv
// Word FIFO feeding the stream unpacker; read data is registered (one cycle after the pop).
module iob_axistream_out_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              cke_i,
  input  logic              rst_i,
  input  logic              wr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              empty_o,
  output logic              full_o,
  output logic [ADDR_W:0]   level_o
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   level;
  logic              do_wr;
  logic              do_rd;

  assign full_o  = (level == (ADDR_W+1)'(DEPTH));
  assign empty_o = (level == '0);
  assign level_o = level;
  assign do_wr   = wr_i & ~full_o;
  assign do_rd   = rd_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        wr_ptr    <= '0;
        rd_ptr    <= '0;
        level     <= '0;
        rd_data_o <= '0;
      end else begin
        if (do_wr) wr_ptr <= wr_ptr + ADDR_W'(1);
        if (do_rd) begin
          rd_ptr    <= rd_ptr + ADDR_W'(1);
          rd_data_o <= mem[rd_ptr];
        end
        case ({do_wr, do_rd})
          2'b10:   level <= level + (ADDR_W+1)'(1);
          2'b01:   level <= level - (ADDR_W+1)'(1);
          default: level <= level;
        endcase
      end
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk_i) begin
    if (cke_i && !rst_i && do_wr) mem[wr_ptr] <= wr_data_i;
  end

endmodule

// File: rtl/iob_axistream_out_tx.sv
// AXI-Stream transmitter: unpacks FIFO words LSB sub-word first and frames them with tlast.
//
// state | meaning
// IDLE  | waiting for enable and a stored word (and no pending frame_done)
// FETCH | FIFO read data arriving, loaded into the word register
// SEND  | presenting sub-word sub_idx on the stream
// DONE  | tlast beat accepted, waiting for frame_clear_i
module iob_axistream_out_tx
  import iob_axistream_out_pkg::*;
#(
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned TDATA_W     = DEF_TDATA_W,
  parameter int unsigned FIFO_ADDR_W = 4
) (
  input  logic                   clk_i,
  input  logic                   cke_i,
  input  logic                   rst_i,
  input  logic                   enable_i,
  input  logic [DATA_W-1:0]      nwords_i,
  input  logic                   frame_clear_i,
  input  logic [FIFO_ADDR_W:0]   fifo_threshold_i,
  input  logic                   wr_valid_i,
  input  logic [DATA_W-1:0]      wr_data_i,
  output logic                   wr_ready_o,
  output logic [TDATA_W-1:0]     axis_tdata_o,
  output logic                   axis_tvalid_o,
  input  logic                   axis_tready_i,
  output logic                   axis_tlast_o,
  output logic                   fifo_empty_o,
  output logic                   fifo_full_o,
  output logic [FIFO_ADDR_W:0]   fifo_level_o,
  output logic [DATA_W-1:0]      beat_count_o,
  output logic                   frame_done_o,
  output logic                   interrupt_o
);

  localparam int unsigned NSUB  = sub_words(DATA_W, TDATA_W);
  localparam int unsigned SUB_W = sub_idx_w(NSUB);

  tx_state_t         state;
  tx_state_t         state_nxt;
  logic [DATA_W-1:0] word_r;
  logic [DATA_W-1:0] word_shifted;
  logic [SUB_W-1:0]  sub_idx;
  logic [DATA_W-1:0] beat_count;
  logic [DATA_W-1:0] beat_count_inc;
  logic              frame_done;
  logic              fifo_rd;
  logic [DATA_W-1:0] fifo_rd_data;
  logic              beat_acc;
  logic              last_sub;
  logic              can_fetch;

  iob_axistream_out_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (FIFO_ADDR_W)
  ) u_fifo (
    .clk_i     (clk_i),
    .cke_i     (cke_i),
    .rst_i     (rst_i),
    .wr_i      (wr_valid_i),
    .wr_data_i (wr_data_i),
    .rd_i      (fifo_rd),
    .rd_data_o (fifo_rd_data),
    .empty_o   (fifo_empty_o),
    .full_o    (fifo_full_o),
    .level_o   (fifo_level_o)
  );

  assign wr_ready_o     = ~fifo_full_o;
  assign interrupt_o    = (fifo_level_o <= fifo_threshold_i);
  assign beat_count_o   = beat_count;
  assign frame_done_o   = frame_done;
  assign beat_count_inc = beat_count + DATA_W'(1);
  assign last_sub       = (sub_idx == SUB_W'(NSUB - 1));
  assign can_fetch      = enable_i & ~fifo_empty_o;
  assign word_shifted   = word_r >> (sub_idx * TDATA_W);

  // nwords_i is compared live, so a lowered target only matches after beat_count wraps.
  assign axis_tvalid_o = (state == ST_SEND);
  assign axis_tdata_o  = axis_tvalid_o ? word_shifted[TDATA_W-1:0] : '0;
  assign axis_tlast_o  = axis_tvalid_o & (nwords_i != '0) & (beat_count_inc == nwords_i);
  assign beat_acc      = axis_tvalid_o & axis_tready_i;

  always_comb begin
    state_nxt = state;
    fifo_rd   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (can_fetch && !frame_done) begin
          fifo_rd   = 1'b1;
          state_nxt = ST_FETCH;
        end
      end
      ST_FETCH: state_nxt = ST_SEND;
      ST_SEND: begin
        if (beat_acc) begin
          if (axis_tlast_o) begin
            state_nxt = frame_clear_i ? ST_IDLE : ST_DONE;
          end else if (last_sub) begin
            if (can_fetch) begin
              fifo_rd   = 1'b1;
              state_nxt = ST_FETCH;
            end else begin
              state_nxt = ST_IDLE;
            end
          end
        end
      end
      ST_DONE: begin
        if (frame_clear_i) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (cke_i) begin
      if (rst_i) begin
        state      <= ST_IDLE;
        word_r     <= '0;
        sub_idx    <= '0;
        beat_count <= '0;
        frame_done <= 1'b0;
      end else begin
        state <= state_nxt;
        if (state == ST_FETCH) begin
          word_r  <= fifo_rd_data;
          sub_idx <= '0;
        end else if (beat_acc && !axis_tlast_o && !last_sub) begin
          sub_idx <= sub_idx + SUB_W'(1);
        end
        // A clear beats a simultaneous tlast acceptance.
        if (frame_clear_i) begin
          beat_count <= '0;
          frame_done <= 1'b0;
        end else if (beat_acc) begin
          beat_count <= beat_count_inc;
          if (axis_tlast_o) frame_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_iob_axistream_out_tx.sv
// Bench for iob_axistream_out_tx: directed frames plus randomized rounds against a word-queue model.
`timescale 1ns/1ps
module tb_iob_axistream_out_tx;

  localparam int DW    = 32;
  localparam int TW    = 8;
  localparam int AW    = 4;
  localparam int R     = DW / TW;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          cke = 1'b1;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic [DW-1:0] nwords = '0;
  logic          frame_clear = 1'b0;
  logic [AW:0]   thr = '0;
  logic          wr_valid = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ready;
  logic [TW-1:0] tdata;
  logic          tvalid;
  logic          tready = 1'b0;
  logic          tlast;
  logic          fifo_empty;
  logic          fifo_full;
  logic [AW:0]   level;
  logic [DW-1:0] beat_count;
  logic          frame_done;
  logic          irq;

  iob_axistream_out_tx #(.DATA_W(DW), .TDATA_W(TW), .FIFO_ADDR_W(AW)) dut (
    .clk_i            (clk),
    .cke_i            (cke),
    .rst_i            (rst),
    .enable_i         (enable),
    .nwords_i         (nwords),
    .frame_clear_i    (frame_clear),
    .fifo_threshold_i (thr),
    .wr_valid_i       (wr_valid),
    .wr_data_i        (wr_data),
    .wr_ready_o       (wr_ready),
    .axis_tdata_o     (tdata),
    .axis_tvalid_o    (tvalid),
    .axis_tready_i    (tready),
    .axis_tlast_o     (tlast),
    .fifo_empty_o     (fifo_empty),
    .fifo_full_o      (fifo_full),
    .fifo_level_o     (level),
    .beat_count_o     (beat_count),
    .frame_done_o     (frame_done),
    .interrupt_o      (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: words accepted into the FIFO, the word being unpacked, frame state.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_word = '0;
  int            m_sub = 0;
  bit            m_have = 0;
  logic [DW-1:0] m_bc = '0;
  bit            m_done = 0;
  bit            model_live = 0;
  logic [TW-1:0] cap_data[$];
  bit            cap_last[$];
  bit            stall_prev = 0;
  logic [TW-1:0] stall_data = '0;
  logic          stall_last = 1'b0;

  always @(negedge clk) begin
    logic [DW-1:0] sh;
    logic [TW-1:0] e_data;
    logic          e_last;
    if (model_live) begin
      chk("beat_count", beat_count, m_bc);
      chk("frame_done", frame_done, m_done);
      if (stall_prev) begin
        chk("hold_tvalid", tvalid, 1'b1);
        chk("hold_tdata", tdata, stall_data);
        chk("hold_tlast", tlast, stall_last);
      end
    end
    stall_prev = model_live && cke && !rst && tvalid && !tready;
    stall_data = tdata;
    stall_last = tlast;
    if (cke) begin
      if (rst) begin
        mq.delete();
        m_have = 0;
        m_sub = 0;
        m_bc = '0;
        m_done = 0;
        model_live = 1;
      end else if (model_live) begin
        if (tvalid && tready) begin
          chk("beat_while_done", m_done, 1'b0);
          if (!m_have) begin
            chk("beat_has_word", mq.size() != 0, 1'b1);
            m_word = (mq.size() != 0) ? mq.pop_front() : '0;
            m_sub = 0;
            m_have = 1;
          end
          sh = m_word >> (m_sub * TW);
          e_data = sh[TW-1:0];
          e_last = (nwords != '0) && ((m_bc + 32'd1) == nwords);
          chk("tdata", tdata, e_data);
          chk("tlast", tlast, e_last);
          cap_data.push_back(tdata);
          cap_last.push_back(tlast);
          m_bc = m_bc + 32'd1;
          if (e_last) begin
            m_done = 1;
            m_have = 0;
          end else begin
            m_sub++;
            if (m_sub == R) m_have = 0;
          end
        end
        if (wr_valid && wr_ready) mq.push_back(wr_data);
        if (frame_clear) begin
          m_bc = '0;
          m_done = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    wr_valid = 1'b1;
    wr_data = w;
    step();
    wr_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int t = 0;
    while (!frame_done && t < budget) begin
      step();
      t++;
    end
    chk("frame_done_wait", frame_done, 1'b1);
  endtask

  task automatic pulse_clear();
    frame_clear = 1'b1;
    step();
    frame_clear = 1'b0;
  endtask

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_b[6];
    int nlast;
    exp_b = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

    // 1: reset values, threshold 0
    rst = 1'b1;
    thr = '0;
    repeat (3) step();
    chk("rst_tvalid", tvalid, 1'b0);
    chk("rst_tlast", tlast, 1'b0);
    chk("rst_tdata", tdata, 8'h00);
    chk("rst_empty", fifo_empty, 1'b1);
    chk("rst_full", fifo_full, 1'b0);
    chk("rst_wr_ready", wr_ready, 1'b1);
    chk("rst_level", level, 5'd0);
    chk("rst_irq", irq, 1'b1);
    chk("rst_beat_count", beat_count, 32'd0);
    chk("rst_frame_done", frame_done, 1'b0);
    rst = 1'b0;
    step();

    // 2: one word, four-beat frame
    nwords = 32'd4;
    tready = 1'b1;
    enable = 1'b1;
    cap_data.delete();
    cap_last.delete();
    push_word(32'h44332211);
    wait_done(30);
    chk("t2_nbeats", cap_data.size(), 4);
    for (int i = 0; i < 4 && i < cap_data.size(); i++) begin
      chk("t2_data", cap_data[i], exp_b[i]);
      chk("t2_last", cap_last[i], i == 3);
    end
    chk("t2_beat_count", beat_count, 32'd4);
    chk("t2_tvalid_done", tvalid, 1'b0);
    enable = 1'b0;
    pulse_clear();
    chk("t2_clear_bc", beat_count, 32'd0);

    // 3: six-beat frame over two words, tail of second word dropped
    nwords = 32'd6;
    push_word(32'h44332211);
    push_word(32'h88776655);
    cap_data.delete();
    cap_last.delete();
    enable = 1'b1;
    wait_done(40);
    step();
    chk("t3_nbeats", cap_data.size(), 6);
    for (int i = 0; i < 6 && i < cap_data.size(); i++) begin
      chk("t3_data", cap_data[i], exp_b[i]);
      chk("t3_last", cap_last[i], i == 5);
    end
    chk("t3_empty", fifo_empty, 1'b1);
    chk("t3_beat_count", beat_count, 32'd6);
    enable = 1'b0;
    pulse_clear();
    chk("t3_clear_bc", beat_count, 32'd0);
    chk("t3_clear_done", frame_done, 1'b0);

    // 4: backpressure on the second beat
    nwords = 32'd4;
    tready = 1'b0;
    enable = 1'b1;
    push_word(32'h44332211);
    for (int i = 0; i < 12 && !tvalid; i++) step();
    chk("t4_first_valid", tvalid, 1'b1);
    chk("t4_first_data", tdata, 8'h11);
    tready = 1'b1;
    step();
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t4_stall_valid", tvalid, 1'b1);
      chk("t4_stall_data", tdata, 8'h22);
      step();
    end
    tready = 1'b1;
    chk("t4_accept_data", tdata, 8'h22);
    step();
    chk("t4_next_data", tdata, 8'h33);
    wait_done(20);
    enable = 1'b0;
    pulse_clear();

    // 5: fill the FIFO, overflow write ignored, threshold boundary
    thr = 5'd15;
    for (int i = 0; i < DEPTH; i++) push_word(32'hA000_0000 + i);
    chk("t5_level", level, 5'd16);
    chk("t5_full", fifo_full, 1'b1);
    chk("t5_wr_ready", wr_ready, 1'b0);
    chk("t5_irq_above", irq, 1'b0);
    push_word(32'hDEAD_BEEF);
    chk("t5_level_after_ovf", level, 5'd16);
    chk("t5_model_words", mq.size(), 16);
    thr = 5'd16;
    #1;
    chk("t5_irq_equal", irq, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t5_flush_level", level, 5'd0);
    chk("t5_flush_empty", fifo_empty, 1'b1);

    // 6: continuous stream, then reset mid-frame
    nwords = '0;
    thr = '0;
    tready = 1'b1;
    cap_data.delete();
    cap_last.delete();
    for (int i = 0; i < 3; i++) push_word($urandom());
    enable = 1'b1;
    for (int i = 0; i < 80 && cap_data.size() < 12; i++) step();
    repeat (3) step();
    chk("t6_nbeats", cap_data.size(), 12);
    nlast = 0;
    foreach (cap_last[i]) nlast += int'(cap_last[i]);
    chk("t6_no_tlast", nlast, 0);
    chk("t6_beat_count", beat_count, 32'd12);
    chk("t6_idle", tvalid, 1'b0);
    push_word($urandom());
    push_word($urandom());
    for (int i = 0; i < 12 && !tvalid; i++) step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("t6_rst_tvalid", tvalid, 1'b0);
    chk("t6_rst_level", level, 5'd0);
    chk("t6_rst_beat_count", beat_count, 32'd0);
    chk("t6_rst_done", frame_done, 1'b0);

    // Randomized rounds: fill with enable low, then stream with random ready and clock enable.
    for (int rnd = 0; rnd < 40; rnd++) begin
      int room;
      int k;
      int avail;
      int t;
      bit quiet;
      enable = 1'b0;
      tready = 1'b0;
      room = DEPTH - mq.size();
      k = (room == 0) ? 0 : $urandom_range((room > 6) ? 6 : room, 1);
      for (int i = 0; i < k; i++) push_word($urandom());
      thr = 5'($urandom_range(16, 0));
      avail = mq.size() * R;
      if (avail == 0) avail = 1;
      case ($urandom_range(3, 0))
        0:       nwords = '0;
        1:       nwords = m_bc + 32'($urandom_range(avail, 1));
        2:       nwords = 32'($urandom_range(40, 1));
        default: nwords = m_bc + 32'($urandom_range(avail + 8, 1));
      endcase
      enable = 1'b1;
      t = 0;
      quiet = m_done || (mq.size() == 0 && !m_have);
      while (!quiet && t < 3000) begin
        tready = ($urandom_range(9, 0) < 7);
        cke = ($urandom_range(9, 0) != 0);
        step();
        t++;
        quiet = m_done || (mq.size() == 0 && !m_have);
      end
      chk("round_finished", quiet, 1'b1);
      cke = 1'b1;
      enable = 1'b0;
      repeat (3) step();
      chk("rnd_tvalid_idle", tvalid, 1'b0);
      chk("rnd_level", level, 5'(mq.size()));
      chk("rnd_empty", fifo_empty, mq.size() == 0);
      chk("rnd_full", fifo_full, mq.size() == DEPTH);
      chk("rnd_wr_ready", wr_ready, mq.size() != DEPTH);
      chk("rnd_irq", irq, mq.size() <= int'(thr));
      if (m_done || $urandom_range(2, 0) == 0) pulse_clear();
    end

    repeat (2) step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
